// File: rtl/instr_pkg.sv
// Shared instruction-set constants: op_idx numbering, opcode/funct codes and the
// per-op field description consumed by both the field ROM and the encoder.
package instr_pkg;

  localparam int NUM_OPS = 54;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_J     = 3'd2,
    FMT_COP0  = 3'd3,
    FMT_FIXED = 3'd4
  } fmt_e;

  // op_idx numbering, matching the core's one-hot decode order
  localparam logic [5:0] OP_ADD     = 6'd0;
  localparam logic [5:0] OP_ADDU    = 6'd1;
  localparam logic [5:0] OP_SUB     = 6'd2;
  localparam logic [5:0] OP_SUBU    = 6'd3;
  localparam logic [5:0] OP_AND     = 6'd4;
  localparam logic [5:0] OP_OR      = 6'd5;
  localparam logic [5:0] OP_XOR     = 6'd6;
  localparam logic [5:0] OP_NOR     = 6'd7;
  localparam logic [5:0] OP_SLT     = 6'd8;
  localparam logic [5:0] OP_SLTU    = 6'd9;
  localparam logic [5:0] OP_SLLV    = 6'd10;
  localparam logic [5:0] OP_SRLV    = 6'd11;
  localparam logic [5:0] OP_SRAV    = 6'd12;
  localparam logic [5:0] OP_SLL     = 6'd13;
  localparam logic [5:0] OP_SRL     = 6'd14;
  localparam logic [5:0] OP_SRA     = 6'd15;
  localparam logic [5:0] OP_JR      = 6'd16;
  localparam logic [5:0] OP_JALR    = 6'd17;
  localparam logic [5:0] OP_MFHI    = 6'd18;
  localparam logic [5:0] OP_MFLO    = 6'd19;
  localparam logic [5:0] OP_MTHI    = 6'd20;
  localparam logic [5:0] OP_MTLO    = 6'd21;
  localparam logic [5:0] OP_DIV     = 6'd22;
  localparam logic [5:0] OP_MULTU   = 6'd23;
  localparam logic [5:0] OP_DIVU    = 6'd24;
  localparam logic [5:0] OP_SYSCALL = 6'd25;
  localparam logic [5:0] OP_BREAK   = 6'd26;
  localparam logic [5:0] OP_TEQ     = 6'd27;
  localparam logic [5:0] OP_CLZ     = 6'd28;
  localparam logic [5:0] OP_MUL     = 6'd29;
  localparam logic [5:0] OP_ADDI    = 6'd30;
  localparam logic [5:0] OP_ADDIU   = 6'd31;
  localparam logic [5:0] OP_ANDI    = 6'd32;
  localparam logic [5:0] OP_ORI     = 6'd33;
  localparam logic [5:0] OP_XORI    = 6'd34;
  localparam logic [5:0] OP_SLTI    = 6'd35;
  localparam logic [5:0] OP_SLTIU   = 6'd36;
  localparam logic [5:0] OP_LUI     = 6'd37;
  localparam logic [5:0] OP_BEQ     = 6'd38;
  localparam logic [5:0] OP_BNE     = 6'd39;
  localparam logic [5:0] OP_LW      = 6'd40;
  localparam logic [5:0] OP_SW      = 6'd41;
  localparam logic [5:0] OP_LB      = 6'd42;
  localparam logic [5:0] OP_LBU     = 6'd43;
  localparam logic [5:0] OP_LHU     = 6'd44;
  localparam logic [5:0] OP_LH      = 6'd45;
  localparam logic [5:0] OP_SB      = 6'd46;
  localparam logic [5:0] OP_SH      = 6'd47;
  localparam logic [5:0] OP_BGEZ    = 6'd48;
  localparam logic [5:0] OP_J       = 6'd49;
  localparam logic [5:0] OP_JAL     = 6'd50;
  localparam logic [5:0] OP_MFC0    = 6'd51;
  localparam logic [5:0] OP_MTC0    = 6'd52;
  localparam logic [5:0] OP_ERET    = 6'd53;

  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_REGIMM   = 6'h01;
  localparam logic [5:0] OPC_J        = 6'h02;
  localparam logic [5:0] OPC_JAL      = 6'h03;
  localparam logic [5:0] OPC_BEQ      = 6'h04;
  localparam logic [5:0] OPC_BNE      = 6'h05;
  localparam logic [5:0] OPC_ADDI     = 6'h08;
  localparam logic [5:0] OPC_ADDIU    = 6'h09;
  localparam logic [5:0] OPC_SLTI     = 6'h0A;
  localparam logic [5:0] OPC_SLTIU    = 6'h0B;
  localparam logic [5:0] OPC_ANDI     = 6'h0C;
  localparam logic [5:0] OPC_ORI      = 6'h0D;
  localparam logic [5:0] OPC_XORI     = 6'h0E;
  localparam logic [5:0] OPC_LUI      = 6'h0F;
  localparam logic [5:0] OPC_COP0     = 6'h10;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OPC_LB       = 6'h20;
  localparam logic [5:0] OPC_LH       = 6'h21;
  localparam logic [5:0] OPC_LW       = 6'h23;
  localparam logic [5:0] OPC_LBU      = 6'h24;
  localparam logic [5:0] OPC_LHU      = 6'h25;
  localparam logic [5:0] OPC_SB       = 6'h28;
  localparam logic [5:0] OPC_SH       = 6'h29;
  localparam logic [5:0] OPC_SW       = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;
  localparam logic [5:0] F_TEQ     = 6'h34;
  localparam logic [5:0] F2_CLZ    = 6'h20;
  localparam logic [5:0] F2_MUL    = 6'h02;

  localparam logic [4:0]  COP0_MF     = 5'd0;
  localparam logic [4:0]  COP0_MT     = 5'd4;
  localparam logic [4:0]  REGIMM_BGEZ = 5'd1;
  localparam logic [31:0] ERET_WORD   = 32'h42000018;

  // Field-use masks, ordered {rs, rt, rd, shamt}
  localparam logic [3:0] U_NONE = 4'b0000;
  localparam logic [3:0] U_RS   = 4'b1000;
  localparam logic [3:0] U_RT   = 4'b0100;
  localparam logic [3:0] U_RD   = 4'b0010;
  localparam logic [3:0] U_SH   = 4'b0001;
  localparam logic [3:0] U_RRR  = 4'b1110;

  // Unused fields take their *_fix value, which lets bgez and mfc0/mtc0
  // carry their constant sub-codes in the rt/rs slots.
  typedef struct packed {
    logic       legal;
    fmt_e       fmt;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       use_rs;
    logic       use_rt;
    logic       use_rd;
    logic       use_sh;
    logic [4:0] rs_fix;
    logic [4:0] rt_fix;
  } field_info_t;

  function automatic field_info_t mk(input fmt_e fmt, input logic [5:0] opcode,
                                     input logic [5:0] funct, input logic [3:0] uses,
                                     input logic [4:0] rs_fix, input logic [4:0] rt_fix);
    field_info_t f;
    f.legal  = 1'b1;
    f.fmt    = fmt;
    f.opcode = opcode;
    f.funct  = funct;
    f.use_rs = uses[3];
    f.use_rt = uses[2];
    f.use_rd = uses[1];
    f.use_sh = uses[0];
    f.rs_fix = rs_fix;
    f.rt_fix = rt_fix;
    return f;
  endfunction

  function automatic field_info_t r_op(input logic [5:0] funct, input logic [3:0] uses);
    return mk(FMT_R, OPC_SPECIAL, funct, uses, 5'd0, 5'd0);
  endfunction

  function automatic field_info_t i_op(input logic [5:0] opcode, input logic [3:0] uses);
    return mk(FMT_I, opcode, 6'h00, uses, 5'd0, 5'd0);
  endfunction

endpackage

// File: rtl/instr_field_rom.sv
// Combinational op_idx -> {format, opcode, funct, field-use} table.
// Indices above the last op return an all-zero entry with legal=0.
module instr_field_rom
  import instr_pkg::*;
(
  input  logic [5:0]  op_idx,
  output field_info_t info
);

  always_comb begin
    info = '0;
    case (op_idx)
      OP_ADD:     info = r_op(F_ADD,     U_RRR);
      OP_ADDU:    info = r_op(F_ADDU,    U_RRR);
      OP_SUB:     info = r_op(F_SUB,     U_RRR);
      OP_SUBU:    info = r_op(F_SUBU,    U_RRR);
      OP_AND:     info = r_op(F_AND,     U_RRR);
      OP_OR:      info = r_op(F_OR,      U_RRR);
      OP_XOR:     info = r_op(F_XOR,     U_RRR);
      OP_NOR:     info = r_op(F_NOR,     U_RRR);
      OP_SLT:     info = r_op(F_SLT,     U_RRR);
      OP_SLTU:    info = r_op(F_SLTU,    U_RRR);
      OP_SLLV:    info = r_op(F_SLLV,    U_RRR);
      OP_SRLV:    info = r_op(F_SRLV,    U_RRR);
      OP_SRAV:    info = r_op(F_SRAV,    U_RRR);
      OP_SLL:     info = r_op(F_SLL,     U_RT | U_RD | U_SH);
      OP_SRL:     info = r_op(F_SRL,     U_RT | U_RD | U_SH);
      OP_SRA:     info = r_op(F_SRA,     U_RT | U_RD | U_SH);
      OP_JR:      info = r_op(F_JR,      U_RS);
      OP_JALR:    info = r_op(F_JALR,    U_RS | U_RD);
      OP_MFHI:    info = r_op(F_MFHI,    U_RD);
      OP_MFLO:    info = r_op(F_MFLO,    U_RD);
      OP_MTHI:    info = r_op(F_MTHI,    U_RS);
      OP_MTLO:    info = r_op(F_MTLO,    U_RS);
      OP_DIV:     info = r_op(F_DIV,     U_RS | U_RT);
      OP_MULTU:   info = r_op(F_MULTU,   U_RS | U_RT);
      OP_DIVU:    info = r_op(F_DIVU,    U_RS | U_RT);
      OP_SYSCALL: info = r_op(F_SYSCALL, U_NONE);
      OP_BREAK:   info = r_op(F_BREAK,   U_NONE);
      OP_TEQ:     info = r_op(F_TEQ,     U_RS | U_RT);
      OP_CLZ:     info = mk(FMT_R, OPC_SPECIAL2, F2_CLZ, U_RRR, 5'd0, 5'd0);
      OP_MUL:     info = mk(FMT_R, OPC_SPECIAL2, F2_MUL, U_RRR, 5'd0, 5'd0);
      OP_ADDI:    info = i_op(OPC_ADDI,  U_RS | U_RT);
      OP_ADDIU:   info = i_op(OPC_ADDIU, U_RS | U_RT);
      OP_ANDI:    info = i_op(OPC_ANDI,  U_RS | U_RT);
      OP_ORI:     info = i_op(OPC_ORI,   U_RS | U_RT);
      OP_XORI:    info = i_op(OPC_XORI,  U_RS | U_RT);
      OP_SLTI:    info = i_op(OPC_SLTI,  U_RS | U_RT);
      OP_SLTIU:   info = i_op(OPC_SLTIU, U_RS | U_RT);
      OP_LUI:     info = i_op(OPC_LUI,   U_RT);
      OP_BEQ:     info = i_op(OPC_BEQ,   U_RS | U_RT);
      OP_BNE:     info = i_op(OPC_BNE,   U_RS | U_RT);
      OP_LW:      info = i_op(OPC_LW,    U_RS | U_RT);
      OP_SW:      info = i_op(OPC_SW,    U_RS | U_RT);
      OP_LB:      info = i_op(OPC_LB,    U_RS | U_RT);
      OP_LBU:     info = i_op(OPC_LBU,   U_RS | U_RT);
      OP_LHU:     info = i_op(OPC_LHU,   U_RS | U_RT);
      OP_LH:      info = i_op(OPC_LH,    U_RS | U_RT);
      OP_SB:      info = i_op(OPC_SB,    U_RS | U_RT);
      OP_SH:      info = i_op(OPC_SH,    U_RS | U_RT);
      OP_BGEZ:    info = mk(FMT_I, OPC_REGIMM, 6'h00, U_RS, 5'd0, REGIMM_BGEZ);
      OP_J:       info = mk(FMT_J, OPC_J,      6'h00, U_NONE, 5'd0, 5'd0);
      OP_JAL:     info = mk(FMT_J, OPC_JAL,    6'h00, U_NONE, 5'd0, 5'd0);
      OP_MFC0:    info = mk(FMT_COP0, OPC_COP0, 6'h00, U_RT | U_RD, COP0_MF, 5'd0);
      OP_MTC0:    info = mk(FMT_COP0, OPC_COP0, 6'h00, U_RT | U_RD, COP0_MT, 5'd0);
      OP_ERET:    info = mk(FMT_FIXED, 6'h00,   6'h00, U_NONE, 5'd0, 5'd0);
      default:    info = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes one instruction per accepted request into a 32-bit word and emits it
// with its image address through a one-deep registered valid/ready stage.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op_idx,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       word_cnt
);

  field_info_t info;
  logic [31:0] word;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic        accept, out_hs;

  instr_field_rom u_rom (
    .op_idx (op_idx),
    .info   (info)
  );

  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  assign rs_f = info.use_rs ? rs    : info.rs_fix;
  assign rt_f = info.use_rt ? rt    : info.rt_fix;
  assign rd_f = info.use_rd ? rd    : 5'd0;
  assign sh_f = info.use_sh ? shamt : 5'd0;

  always_comb begin
    word = '0;
    case (info.fmt)
      FMT_R, FMT_COP0: word = {info.opcode, rs_f, rt_f, rd_f, sh_f, info.funct};
      FMT_I:           word = {info.opcode, rs_f, rt_f, imm};
      FMT_J:           word = {info.opcode, target};
      FMT_FIXED:       word = ERET_WORD;
      default:         word = '0;
    endcase
  end

  // out_addr doubles as the next-word address while the stage is empty, so a
  // handshake or base_load updates it whether or not a new word arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (accept && info.legal) begin
        out_valid <= 1'b1;
        out_instr <= word;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (base_load)
        out_addr <= base_addr;
      else if (out_hs)
        out_addr <= out_addr + ADDR_W'(1);

      if (out_hs && word_cnt != 16'hFFFF)
        word_cnt <= word_cnt + 16'd1;

      if (accept && !info.legal)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed vector table plus hand-written handshake, wrap, error and reset
// sequences for instr_encoder.
module tb_instr_encoder;

  localparam int ADDR_W = 11;
  localparam int NV = 21;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        op_idx;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic              err_clr;
  logic [15:0]       word_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_idx    (op_idx),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .base_load (base_load),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_clr   (err_clr),
    .word_cnt  (word_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                               input logic [4:0] a_rd, input logic [4:0] a_sh,
                               input logic [15:0] a_imm, input logic [25:0] a_tgt);
    in_valid = 1'b1;
    op_idx   = op;
    rs       = a_rs;
    rt       = a_rt;
    rd       = a_rd;
    shamt    = a_sh;
    imm      = a_imm;
    target   = a_tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    base_load = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Reference decoder written from the ISA codes; returns 63 for unknown words
  function automatic int decode_idx(input logic [31:0] w);
    logic [5:0] opc, fn;
    opc = w[31:26];
    fn  = w[5:0];
    if (w == 32'h42000018) return 53;
    case (opc)
      6'h00: case (fn)
        6'h20: return 0;  6'h21: return 1;  6'h22: return 2;  6'h23: return 3;
        6'h24: return 4;  6'h25: return 5;  6'h26: return 6;  6'h27: return 7;
        6'h2A: return 8;  6'h2B: return 9;  6'h04: return 10; 6'h06: return 11;
        6'h07: return 12; 6'h00: return 13; 6'h02: return 14; 6'h03: return 15;
        6'h08: return 16; 6'h09: return 17; 6'h10: return 18; 6'h12: return 19;
        6'h11: return 20; 6'h13: return 21; 6'h1A: return 22; 6'h19: return 23;
        6'h1B: return 24; 6'h0C: return 25; 6'h0D: return 26; 6'h34: return 27;
        default: return 63;
      endcase
      6'h1C: return (fn == 6'h20) ? 28 : (fn == 6'h02) ? 29 : 63;
      6'h08: return 30; 6'h09: return 31; 6'h0C: return 32; 6'h0D: return 33;
      6'h0E: return 34; 6'h0A: return 35; 6'h0B: return 36; 6'h0F: return 37;
      6'h04: return 38; 6'h05: return 39; 6'h23: return 40; 6'h2B: return 41;
      6'h20: return 42; 6'h24: return 43; 6'h25: return 44; 6'h21: return 45;
      6'h28: return 46; 6'h29: return 47;
      6'h01: return (w[20:16] == 5'd1) ? 48 : 63;
      6'h02: return 49;
      6'h03: return 50;
      6'h10: return (w[25:21] == 5'd0) ? 51 : (w[25:21] == 5'd4) ? 52 : 63;
      default: return 63;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{6'd0,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0,       32'h00221820};
    vecs[1]  = '{6'd13, 5'd7,  5'd4,  5'd5,  5'd3, 16'h0000, 26'h0,       32'h000428C0};
    vecs[2]  = '{6'd16, 5'd31, 5'd9,  5'd9,  5'd0, 16'h0000, 26'h0,       32'h03E00008};
    vecs[3]  = '{6'd19, 5'd3,  5'd3,  5'd4,  5'd0, 16'h0000, 26'h0,       32'h00002012};
    vecs[4]  = '{6'd25, 5'd1,  5'd2,  5'd3,  5'd4, 16'hFFFF, 26'h0,       32'h0000000C};
    vecs[5]  = '{6'd27, 5'd2,  5'd3,  5'd7,  5'd0, 16'h0000, 26'h0,       32'h00430034};
    vecs[6]  = '{6'd28, 5'd4,  5'd0,  5'd2,  5'd0, 16'h0000, 26'h0,       32'h70801020};
    vecs[7]  = '{6'd29, 5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0,       32'h70221802};
    vecs[8]  = '{6'd31, 5'd29, 5'd29, 5'd0,  5'd0, 16'hFFF8, 26'h0,       32'h27BDFFF8};
    vecs[9]  = '{6'd37, 5'd5,  5'd1,  5'd0,  5'd0, 16'h1234, 26'h0,       32'h3C011234};
    vecs[10] = '{6'd40, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0010, 26'h0,       32'h8FBF0010};
    vecs[11] = '{6'd48, 5'd3,  5'd9,  5'd0,  5'd0, 16'h0004, 26'h0,       32'h04610004};
    vecs[12] = '{6'd49, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h0100000, 32'h08100000};
    vecs[13] = '{6'd50, 5'd31, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
    vecs[14] = '{6'd51, 5'd5,  5'd8,  5'd12, 5'd0, 16'h0000, 26'h0,       32'h40086000};
    vecs[15] = '{6'd52, 5'd5,  5'd8,  5'd12, 5'd0, 16'h0000, 26'h0,       32'h40886000};
    vecs[16] = '{6'd53, 5'd1,  5'd1,  5'd1,  5'd1, 16'h0001, 26'h1,       32'h42000018};
    vecs[17] = '{6'd41, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0014, 26'h0,       32'hAFBF0014};
    vecs[18] = '{6'd17, 5'd31, 5'd5,  5'd31, 5'd0, 16'h0000, 26'h0,       32'h03E0F809};
    vecs[19] = '{6'd5,  5'd8,  5'd9,  5'd10, 5'd0, 16'hFFFF, 26'h3AAAAAA, 32'h01095025};
    vecs[20] = '{6'd32, 5'd4,  5'd5,  5'd6,  5'd7, 16'h00FF, 26'h0,       32'h308500FF};

    rst_n = 1'b0; in_valid = 1'b0; base_load = 1'b0; base_addr = '0;
    err_clr = 1'b0; out_ready = 1'b0;
    op_idx = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    step();
    step();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First word: add lands one cycle later at address 0
    applyStimulus(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    step();
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_instr", out_instr, 32'h00221820);
    checkOutput("first_addr", 32'(out_addr), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checkOutput("first_drain_valid", 32'(out_valid), 32'd0);
    checkOutput("first_drain_cnt", 32'(word_cnt), 32'd1);

    // Vector table, one word per cycle
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      step();
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
      checkOutput($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(i));
    end
    in_valid = 1'b0;
    step();
    checkOutput("vec_drain_valid", 32'(out_valid), 32'd0);
    checkOutput("vec_word_cnt", 32'(word_cnt), 32'(NV));

    // Address wrap after base_load of the top address
    doReset();
    base_load = 1'b1; base_addr = 11'h7FF;
    step();
    base_load = 1'b0; out_ready = 1'b1;
    applyStimulus(6'd31, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 26'h0);
    step();
    checkOutput("wrap_addr0", 32'(out_addr), 32'h7FF);
    applyStimulus(6'd31, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0002, 26'h0);
    step();
    checkOutput("wrap_addr1", 32'(out_addr), 32'h000);
    checkOutput("wrap_instr1", out_instr, 32'h24220002);
    in_valid = 1'b0;
    step();
    checkOutput("wrap_word_cnt", 32'(word_cnt), 32'd2);

    // Backpressure: output held stable, then full-rate streaming
    doReset();
    applyStimulus(6'd13, 5'd0, 5'd4, 5'd5, 5'd3, 16'h0, 26'h0);
    step();
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    applyStimulus(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d_instr", k), out_instr, 32'h000428C0);
      checkOutput($sformatf("stall%0d_addr", k), 32'(out_addr), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    checkOutput("stream0_instr", out_instr, 32'h00221820);
    checkOutput("stream0_addr", 32'(out_addr), 32'd1);
    applyStimulus(6'd37, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
    step();
    checkOutput("stream1_instr", out_instr, 32'h3C011234);
    checkOutput("stream1_addr", 32'(out_addr), 32'd2);
    applyStimulus(6'd49, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    step();
    checkOutput("stream2_instr", out_instr, 32'h08100000);
    checkOutput("stream2_addr", 32'(out_addr), 32'd3);
    in_valid = 1'b0;
    step();
    checkOutput("stream_drain_valid", 32'(out_valid), 32'd0);
    checkOutput("stream_word_cnt", 32'(word_cnt), 32'd4);

    // base_load while a word is pending relocates that word
    out_ready = 1'b0;
    applyStimulus(6'd53, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    checkOutput("pend_addr", 32'(out_addr), 32'd4);
    in_valid = 1'b0; base_load = 1'b1; base_addr = 11'h100;
    step();
    base_load = 1'b0;
    checkOutput("reloc_addr", 32'(out_addr), 32'h100);
    checkOutput("reloc_instr", out_instr, 32'h42000018);
    out_ready = 1'b1;
    applyStimulus(6'd25, 5'd3, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0);
    step();
    checkOutput("reloc_next_addr", 32'(out_addr), 32'h101);
    checkOutput("reloc_next_instr", out_instr, 32'h0000000C);
    in_valid = 1'b0;
    step();
    checkOutput("reloc_word_cnt", 32'(word_cnt), 32'd6);

    // Reset discards a pending word and clears the counter
    out_ready = 1'b0;
    applyStimulus(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    step();
    checkOutput("prerst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("midrst_addr", 32'(out_addr), 32'd0);
    checkOutput("midrst_instr", out_instr, 32'd0);
    rst_n = 1'b1;

    // Illegal op: no output, sticky err, set beats clear
    out_ready = 1'b1;
    applyStimulus(6'd60, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    step();
    checkOutput("ill_valid", 32'(out_valid), 32'd0);
    checkOutput("ill_err", 32'(err), 32'd1);
    checkOutput("ill_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("ill_addr", 32'(out_addr), 32'd0);
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    checkOutput("clr_err", 32'(err), 32'd0);
    applyStimulus(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    checkOutput("ill_beats_clr", 32'(err), 32'd1);
    in_valid = 1'b0; err_clr = 1'b0;
    step();
    checkOutput("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("clr_err2", 32'(err), 32'd0);
    applyStimulus(6'd53, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    checkOutput("eret_valid", 32'(out_valid), 32'd1);
    checkOutput("eret_instr", out_instr, 32'h42000018);
    checkOutput("eret_addr", 32'(out_addr), 32'd0);
    in_valid = 1'b0;
    step();

    // Every op with random fields must decode back to its own index
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 54; i++) begin
      applyStimulus(6'(i), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 26'($urandom));
      step();
      checkOutput($sformatf("dec%0d_idx", i), 32'(decode_idx(out_instr)), 32'(i));
      checkOutput($sformatf("dec%0d_addr", i), 32'(out_addr), 32'(i));
    end
    in_valid = 1'b0;
    step();
    checkOutput("dec_word_cnt", 32'(word_cnt), 32'd54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
